// File: rtl/auth_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : auth_request_arbiter
//  Description : Round-robin arbiter between PD and DEBUG authentication
//                requesters in front of a single authentication driver.
//  Revision    : 1.0  initial release
// ============================================================================

module auth_request_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pd_req_valid,
    input  logic [5:0] pd_req,
    output logic       pd_req_ready,
    input  logic       dbg_req_valid,
    input  logic [5:0] dbg_req,
    output logic       dbg_req_ready,
    output logic [7:0] drv_request,
    input  logic       drv_pd_in_ready,
    input  logic       drv_dbg_in_ready,
    input  logic       drv_msg_ready,
    output logic       drv_ack,
    output logic       pd_done,
    output logic       dbg_done,
    output logic       pd_err,
    output logic       dbg_err,
    output logic       busy
);

    localparam int S_IDLE   = 0;
    localparam int S_ISSUE  = 1;
    localparam int S_WAIT   = 2;
    localparam int S_ACK    = 3;
    localparam int S_ABORT  = 4;
    localparam int S_REJECT = 5;

    localparam logic [5:0] ST_IDLE   = 6'b000001;
    localparam logic [5:0] ST_ISSUE  = 6'b000010;
    localparam logic [5:0] ST_WAIT   = 6'b000100;
    localparam logic [5:0] ST_ACK    = 6'b001000;
    localparam logic [5:0] ST_ABORT  = 6'b010000;
    localparam logic [5:0] ST_REJECT = 6'b100000;

    localparam logic [1:0] REQR_PD  = 2'b01;
    localparam logic [1:0] REQR_DBG = 2'b10;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [5:0]         state_q, state_d;
    logic               pd_full_q, pd_full_d;
    logic               dbg_full_q, dbg_full_d;
    logic [5:0]         pd_slot_q, pd_slot_d;
    logic [5:0]         dbg_slot_q, dbg_slot_d;
    logic               grant_dbg_q, grant_dbg_d;
    logic               last_grant_dbg_q, last_grant_dbg_d;
    logic [7:0]         drv_request_q, drv_request_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic       w_pd_accept;
    logic       w_dbg_accept;
    logic       w_any_full;
    logic       w_pick_dbg;
    logic [5:0] w_pick_word;
    logic       w_pick_legal;
    logic       w_in_ready;
    logic       w_timeout;
    logic       w_final;

    assign w_pd_accept  = pd_req_valid & ~pd_full_q;
    assign w_dbg_accept = dbg_req_valid & ~dbg_full_q;
    assign w_any_full   = pd_full_q | dbg_full_q;
    // DEBUG wins only when alone or when PD was served last
    assign w_pick_dbg   = dbg_full_q & (~pd_full_q | ~last_grant_dbg_q);
    assign w_pick_word  = w_pick_dbg ? dbg_slot_q : pd_slot_q;
    assign w_pick_legal = ^w_pick_word[5:4];
    assign w_in_ready   = grant_dbg_q ? drv_dbg_in_ready : drv_pd_in_ready;
    // >= keeps the abort reachable even if in_ready lands on the last cycle
    assign w_timeout    = (timer_q >= TIMER_LAST);
    assign w_final      = state_q[S_ACK] | state_q[S_ABORT] | state_q[S_REJECT];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_any_full) begin
                    state_d = w_pick_legal ? ST_ISSUE : ST_REJECT;
                end
            end
            ST_ISSUE: begin
                if (w_in_ready) begin
                    state_d = ST_WAIT;
                end else if (w_timeout) begin
                    state_d = ST_ABORT;
                end
            end
            ST_WAIT: begin
                if (drv_msg_ready) begin
                    state_d = ST_ACK;
                end else if (w_timeout) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ACK, ST_ABORT, ST_REJECT: state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pd_req_ready  = ~pd_full_q;
        dbg_req_ready = ~dbg_full_q;
        drv_request   = drv_request_q;
        busy          = ~state_q[S_IDLE];
        drv_ack       = state_q[S_ACK] | state_q[S_ABORT];
        pd_done       = state_q[S_ACK] & ~grant_dbg_q;
        dbg_done      = state_q[S_ACK] & grant_dbg_q;
        pd_err        = (state_q[S_ABORT] | state_q[S_REJECT]) & ~grant_dbg_q;
        dbg_err       = (state_q[S_ABORT] | state_q[S_REJECT]) & grant_dbg_q;
    end

    always_comb begin
        pd_full_d        = pd_full_q;
        dbg_full_d       = dbg_full_q;
        pd_slot_d        = w_pd_accept ? pd_req : pd_slot_q;
        dbg_slot_d       = w_dbg_accept ? dbg_req : dbg_slot_q;
        grant_dbg_d      = state_q[S_IDLE] ? w_pick_dbg : grant_dbg_q;
        last_grant_dbg_d = w_final ? grant_dbg_q : last_grant_dbg_q;
        drv_request_d    = '0;
        timer_d          = '0;

        if (w_final && !grant_dbg_q) begin
            pd_full_d = 1'b0;
        end else if (w_pd_accept) begin
            pd_full_d = 1'b1;
        end

        if (w_final && grant_dbg_q) begin
            dbg_full_d = 1'b0;
        end else if (w_dbg_accept) begin
            dbg_full_d = 1'b1;
        end

        // Request word is loaded on entry to ISSUE and held only while there
        if (state_d == ST_ISSUE) begin
            drv_request_d = state_q[S_IDLE] ?
                            {(w_pick_dbg ? REQR_DBG : REQR_PD), w_pick_word} :
                            drv_request_q;
        end

        if (state_q[S_ISSUE] || state_q[S_WAIT]) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pd_full_q        <= 1'b0;
            dbg_full_q       <= 1'b0;
            pd_slot_q        <= '0;
            dbg_slot_q       <= '0;
            grant_dbg_q      <= 1'b0;
            last_grant_dbg_q <= 1'b1;
            drv_request_q    <= '0;
            timer_q          <= '0;
        end else begin
            pd_full_q        <= pd_full_d;
            dbg_full_q       <= dbg_full_d;
            pd_slot_q        <= pd_slot_d;
            dbg_slot_q       <= dbg_slot_d;
            grant_dbg_q      <= grant_dbg_d;
            last_grant_dbg_q <= last_grant_dbg_d;
            drv_request_q    <= drv_request_d;
            timer_q          <= timer_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_auth_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_auth_request_arbiter
//  Description : Self-checking bench for auth_request_arbiter: directed
//                scenarios plus randomized traffic against a timeline model.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_auth_request_arbiter;

    localparam int TO = 8;

    logic       clk;
    logic       reset;
    logic       pd_req_valid;
    logic [5:0] pd_req;
    logic       pd_req_ready;
    logic       dbg_req_valid;
    logic [5:0] dbg_req;
    logic       dbg_req_ready;
    logic [7:0] drv_request;
    logic       drv_pd_in_ready;
    logic       drv_dbg_in_ready;
    logic       drv_msg_ready;
    logic       drv_ack;
    logic       pd_done;
    logic       dbg_done;
    logic       pd_err;
    logic       dbg_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    auth_request_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .TIMER_W        (16)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .pd_req_valid     (pd_req_valid),
        .pd_req           (pd_req),
        .pd_req_ready     (pd_req_ready),
        .dbg_req_valid    (dbg_req_valid),
        .dbg_req          (dbg_req),
        .dbg_req_ready    (dbg_req_ready),
        .drv_request      (drv_request),
        .drv_pd_in_ready  (drv_pd_in_ready),
        .drv_dbg_in_ready (drv_dbg_in_ready),
        .drv_msg_ready    (drv_msg_ready),
        .drv_ack          (drv_ack),
        .pd_done          (pd_done),
        .dbg_done         (dbg_done),
        .pd_err           (pd_err),
        .dbg_err          (dbg_err),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pd_rdy, dbg_rdy, busy, ack, pd_done, dbg_done, pd_err, dbg_err, request}
    function automatic logic [15:0] obs();
        return {pd_req_ready, dbg_req_ready, busy, drv_ack, pd_done, dbg_done,
                pd_err, dbg_err, drv_request};
    endfunction

    function automatic logic [5:0] rand_word();
        logic [5:0] w;
        w = 6'($urandom);
        if ($urandom_range(0, 5) != 0) begin
            w[5:4] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        end
        return w;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset            = 1'b0;
        pd_req_valid     = 1'b0;
        pd_req           = 6'd0;
        dbg_req_valid    = 1'b0;
        dbg_req          = 6'd0;
        drv_pd_in_ready  = 1'b0;
        drv_dbg_in_ready = 1'b0;
        drv_msg_ready    = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (obs() !== 16'hC000) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs(), 16'hC000);
        end
        next_cycle();
        reset         = 1'b1;
        pd_req_valid  = 1'b1;
        pd_req        = 6'b010001;
        dbg_req_valid = 1'b1;
        dbg_req       = 6'b100001;
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            idle_inputs();
            @(negedge clk);
            checks++;
            if (obs() !== 16'hC000) begin
                errors++;
                $display("FAIL reset_blocks_accept cycle %0d: got %h expected %h", c, obs(), 16'hC000);
            end
            next_cycle();
        end
    endtask

    task automatic test_single_pd();
        logic [15:0] exp_t [10];
        exp_t = '{16'hC000, 16'h4000, 16'h6051, 16'h6051, 16'h6051,
                  16'h6000, 16'h6000, 16'h6000, 16'h7800, 16'hC000};
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            case (c)
                0: begin pd_req_valid = 1'b1; pd_req = 6'b010001; end
                4: drv_pd_in_ready = 1'b1;
                7: drv_msg_ready = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            checks++;
            if (obs() !== exp_t[c]) begin
                errors++;
                $display("FAIL single_pd cycle %0d: got %h expected %h", c, obs(), exp_t[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_t [10];
        exp_t = '{16'hC000, 16'h0000, 16'h2060, 16'h2000, 16'h3800,
                  16'h8000, 16'hA09C, 16'hA000, 16'hB400, 16'hC000};
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            case (c)
                0: begin
                    pd_req_valid = 1'b1;  pd_req  = 6'b100000;
                    dbg_req_valid = 1'b1; dbg_req = 6'b011100;
                end
                2: begin drv_pd_in_ready = 1'b1; drv_dbg_in_ready = 1'b0; end
                3: drv_msg_ready = 1'b1;
                6: drv_dbg_in_ready = 1'b1;
                7: drv_msg_ready = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            checks++;
            if (obs() !== exp_t[c]) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs(), exp_t[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reject();
        logic [15:0] exp_t [4];
        exp_t = '{16'hC000, 16'h8000, 16'hA100, 16'hC000};
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            if (c == 0) begin
                dbg_req_valid = 1'b1;
                dbg_req       = 6'b001101;
            end
            drv_dbg_in_ready = (c == 2);
            @(negedge clk);
            checks++;
            if (obs() !== exp_t[c]) begin
                errors++;
                $display("FAIL reject cycle %0d: got %h expected %h", c, obs(), exp_t[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        logic [15:0] e;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            idle_inputs();
            if (c == 0) begin
                pd_req_valid = 1'b1;
                pd_req       = 6'b010010;
            end
            drv_dbg_in_ready = (c >= 2 && c <= 9);
            if (c == 0 || c == 11) e = 16'hC000;
            else if (c == 1)       e = 16'h4000;
            else if (c == 10)      e = 16'h7200;
            else                   e = 16'h6052;
            @(negedge clk);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL timeout cycle %0d: got %h expected %h", c, obs(), e);
            end
            next_cycle();
        end
    endtask

    task automatic test_msg_at_timeout();
        logic [15:0] e;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            idle_inputs();
            case (c)
                0: begin pd_req_valid = 1'b1; pd_req = 6'b010001; end
                3: drv_pd_in_ready = 1'b1;
                9: drv_msg_ready = 1'b1;
                default: ;
            endcase
            if (c == 0 || c == 11)     e = 16'hC000;
            else if (c == 1)           e = 16'h4000;
            else if (c == 2 || c == 3) e = 16'h6051;
            else if (c == 10)          e = 16'h7800;
            else                       e = 16'h6000;
            @(negedge clk);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL msg_at_timeout cycle %0d: got %h expected %h", c, obs(), e);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_t [8];
        exp_t = '{16'hC000, 16'h4000, 16'h2061, 16'h2000, 16'h2000,
                  16'hC000, 16'hC000, 16'hC000};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            case (c)
                0: begin pd_req_valid = 1'b1; pd_req = 6'b100001; end
                1: begin dbg_req_valid = 1'b1; dbg_req = 6'b100010; end
                2: drv_pd_in_ready = 1'b1;
                4: begin reset = 1'b1; drv_msg_ready = 1'b1; end
                default: ;
            endcase
            @(negedge clk);
            checks++;
            if (obs() !== exp_t[c]) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", c, obs(), exp_t[c]);
            end
            next_cycle();
        end
    endtask

    // Each grant is planned as a whole timeline when the model leaves idle
    task automatic test_random();
        bit         m_pd_full, m_dbg_full, m_last_dbg, m_active, m_gdbg;
        bit         pd_acc, dbg_acc;
        bit [5:0]   m_pd_word, m_dbg_word, w;
        bit [7:0]   m_word;
        bit [15:0]  e;
        int         t_start, t_end, t_in, t_msg, t_req_last, kind, d1, abort_at;
        apply_reset();
        m_pd_full = 0; m_dbg_full = 0; m_last_dbg = 1; m_active = 0; m_gdbg = 0;
        m_pd_word = 0; m_dbg_word = 0; m_word = 0;
        t_start = -1; t_end = -1; t_in = -1; t_msg = -1; t_req_last = -1; kind = 0;
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            pd_req_valid  = ($urandom_range(0, 2) == 0);
            pd_req        = rand_word();
            dbg_req_valid = ($urandom_range(0, 2) == 0);
            dbg_req       = rand_word();
            if (m_active && !m_gdbg) drv_pd_in_ready = (c == t_in);
            else                     drv_pd_in_ready = ($urandom_range(0, 1) == 1);
            if (m_active && m_gdbg)  drv_dbg_in_ready = (c == t_in);
            else                     drv_dbg_in_ready = ($urandom_range(0, 1) == 1);
            drv_msg_ready = m_active && (kind == 0) && (c == t_msg);

            e = '0;
            e[15] = !m_pd_full;
            e[14] = !m_dbg_full;
            e[13] = m_active;
            if (m_active && c == t_end) begin
                e[12] = (kind != 2);
                if (kind == 0) e[m_gdbg ? 10 : 11] = 1'b1;
                else           e[m_gdbg ? 8 : 9]   = 1'b1;
            end
            if (m_active && kind != 2 && c >= t_start && c <= t_req_last) e[7:0] = m_word;
            @(negedge clk);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", c, obs(), e);
            end

            pd_acc  = pd_req_valid && !m_pd_full;
            dbg_acc = dbg_req_valid && !m_dbg_full;
            if (m_active) begin
                if (c == t_end) begin
                    if (m_gdbg) m_dbg_full = 0;
                    else        m_pd_full  = 0;
                    m_last_dbg = m_gdbg;
                    m_active   = 0;
                end
            end else if (m_pd_full || m_dbg_full) begin
                m_gdbg   = m_dbg_full && (!m_pd_full || !m_last_dbg);
                w        = m_gdbg ? m_dbg_word : m_pd_word;
                m_word   = {(m_gdbg ? 2'b10 : 2'b01), w};
                m_active = 1;
                t_start  = c + 1;
                t_in     = -1;
                t_msg    = -1;
                if (w[5:4] == 2'b00 || w[5:4] == 2'b11) begin
                    kind  = 2;
                    t_end = c + 1;
                end else begin
                    d1 = $urandom_range(0, TO);
                    if (d1 >= TO) begin
                        kind       = 1;
                        t_end      = t_start + TO;
                        t_req_last = t_end - 1;
                    end else begin
                        t_in       = t_start + d1;
                        t_req_last = t_in;
                        t_msg      = t_in + 1 + $urandom_range(0, 6);
                        abort_at   = (t_start + TO > t_in + 2) ? t_start + TO : t_in + 2;
                        if (t_msg < abort_at) begin
                            kind  = 0;
                            t_end = t_msg + 1;
                        end else begin
                            kind  = 1;
                            t_end = abort_at;
                            t_msg = -1;
                        end
                    end
                end
            end
            if (pd_acc)  begin m_pd_full  = 1; m_pd_word  = pd_req;  end
            if (dbg_acc) begin m_dbg_full = 1; m_dbg_word = dbg_req; end
            next_cycle();
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single_pd();
        test_back_to_back();
        test_reject();
        test_timeout();
        test_msg_at_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
